mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit. Consumes the EX/MEM pipeline register outputs: RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM and funct3M.
- Drives a valid/ready data-memory bus and returns aligned, sign- or zero-extended load data towards the MEM/WB register.
- Asserts StallM so the EX/MEM register and upstream stages hold while a bus transaction is outstanding.
- Sits between the EX/MEM register and data memory; StallM feeds the hazard unit.

---
 rtl/mem_stage_lsu_if.sv | 37 +++
 rtl/mem_stage_lsu.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_if
// Data-memory valid/ready bus between the memory-stage LSU (master) and the
// data memory or its responder (slave).
//
// Signals:
//   dmem_req     master->slave  request valid
//   dmem_we      master->slave  1 = write
//   dmem_addr    master->slave  word-aligned byte address
//   dmem_wdata   master->slave  lane-replicated store data
//   dmem_be      master->slave  byte enables
//   dmem_gnt     slave->master  request accepted
//   dmem_rvalid  slave->master  read data valid
//   dmem_rdata   slave->master  read data
// -----------------------------------------------------------------------------
interface mem_stage_lsu_if #(
   parameter int XLEN = 32
);
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [3:0]      dmem_be;
   logic            dmem_gnt;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// Memory-stage load/store unit. Takes the EX/MEM register outputs, runs one
// data-memory bus transaction per aligned access, formats load data for the
// MEM/WB register and stalls the pipeline while the transaction is in flight.
//
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   RegWriteM        register write enable of the MEM instruction (unused)
//   ResultSrcM       2'b01 marks a load
//   MemWriteM        marks a store (wins over a load)
//   ALUResultM       effective byte address
//   WriteDataM       store data (low bits)
//   funct3M          000 B, 001 H, 010 W, 100 BU, 101 HU; others act as W
//   dmem             data-memory bus, master side
//   ReadDataM        formatted load result, held until the next load completes
//   StallM           hold the EX/MEM register and upstream stages
//   MisalignedM      one-cycle misaligned-access flag
//   BusErrM          one-cycle bus timeout flag
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
   parameter int TIMEOUT = 16,
   parameter int XLEN    = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   RegWriteM,
   input  logic [1:0]             ResultSrcM,
   input  logic                   MemWriteM,
   input  logic [31:0]            ALUResultM,
   input  logic [31:0]            WriteDataM,
   input  logic [2:0]             funct3M,
   mem_stage_lsu_if.master        dmem,
   output logic [31:0]            ReadDataM,
   output logic                   StallM,
   output logic                   MisalignedM,
   output logic                   BusErrM
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t          state_q, state_d;

   logic [31:0]     addr_q;
   logic            we_q;
   logic [31:0]     wdata_q;
   logic [3:0]      be_q;
   logic [1:0]      off_q;
   logic            size_b_q, size_h_q, uns_q;
   logic [CW-1:0]   cnt_q;
   logic [31:0]     rdata_q;
   logic            buserr_q;

   // RegWriteM is carried for completeness but never steers the LSU.
   logic            unused_regwrite;
   assign unused_regwrite = RegWriteM;

   // ---------------------------------------------------------------- decode
   logic            is_store, access, misaligned;
   logic [1:0]      off;
   logic            size_b, size_h, uns;
   logic [3:0]      be_fmt;
   logic [31:0]     wdata_fmt;

   assign is_store   = MemWriteM;
   assign access     = MemWriteM || (ResultSrcM == 2'b01);
   assign off        = ALUResultM[1:0];
   assign size_b     = (funct3M == 3'b000) || (funct3M == 3'b100);
   assign size_h     = (funct3M == 3'b001) || (funct3M == 3'b101);
   assign uns        = funct3M[2];
   assign misaligned = size_h ? off[0] : (!size_b && (off != 2'b00));

   always_comb begin
      be_fmt    = 4'b1111;
      wdata_fmt = WriteDataM;
      if (size_b) begin
         be_fmt    = 4'b0001 << off;
         wdata_fmt = {4{WriteDataM[7:0]}};
      end else if (size_h) begin
         be_fmt    = 4'b0011 << off;
         wdata_fmt = {2{WriteDataM[15:0]}};
      end
   end

   // ----------------------------------------------------- load formatting
   logic [31:0]     rd_shift;
   logic [31:0]     rd_fmt;

   assign rd_shift = dmem.dmem_rdata >> {off_q, 3'b000};

   always_comb begin
      rd_fmt = dmem.dmem_rdata;
      if (size_b_q) begin
         rd_fmt = uns_q ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end else if (size_h_q) begin
         rd_fmt = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
   end

   // --------------------------------------------------------------- timeout
   // The counter holds the number of completed cycles in the current REQ/WAIT
   // phase, so hitting TIMEOUT-1 during a cycle means this is the TIMEOUT-th
   // cycle; BusErrM is registered and shows in the following DONE cycle.
   logic            timeout_hit, timeout_evt;

   assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);
   assign timeout_evt = timeout_hit &&
                        (((state_q == S_REQ)  && !dmem.dmem_gnt) ||
                         ((state_q == S_WAIT) && !dmem.dmem_rvalid));

   // -------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (access && !misaligned) state_d = S_REQ;
         S_REQ: begin
            // gnt wins over a timeout landing in the same cycle
            if (dmem.dmem_gnt)   state_d = we_q ? S_DONE : S_WAIT;
            else if (timeout_hit) state_d = S_DONE;
         end
         S_WAIT: if (dmem.dmem_rvalid || timeout_hit) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------- outputs
   // The combinational flags are qualified with rst_n so that a held access
   // on the inputs cannot show through while reset is asserted.
   always_comb begin
      dmem.dmem_req = (state_q == S_REQ);
      StallM        = rst_n && (((state_q == S_IDLE) && access && !misaligned) ||
                                (state_q == S_REQ) || (state_q == S_WAIT));
      MisalignedM   = rst_n && (state_q == S_IDLE) && access && misaligned;
   end

   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign dmem.dmem_be    = be_q;
   assign ReadDataM       = rdata_q;
   assign BusErrM         = buserr_q;

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         be_q     <= '0;
         off_q    <= '0;
         size_b_q <= 1'b0;
         size_h_q <= 1'b0;
         uns_q    <= 1'b0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         buserr_q <= 1'b0;
      end else begin
         if ((state_q == S_IDLE) && access && !misaligned) begin
            addr_q   <= {ALUResultM[31:2], 2'b00};
            we_q     <= is_store;
            wdata_q  <= wdata_fmt;
            be_q     <= be_fmt;
            off_q    <= off;
            size_b_q <= size_b;
            size_h_q <= size_h;
            uns_q    <= uns;
         end

         if ((state_d != state_q) && ((state_d == S_REQ) || (state_d == S_WAIT))) begin
            cnt_q <= '0;
         end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            cnt_q <= cnt_q + CW'(1);
         end

         buserr_q <= timeout_evt;

         if ((state_q == S_WAIT) && dmem.dmem_rvalid) begin
            rdata_q <= rd_fmt;
         end else if (timeout_evt && !we_q) begin
            rdata_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Scoreboard bench: the issuing process computes expected bus fields and
// completion results from the access rules and queues them; a monitor process
// compares whenever the DUT drives a request or completes an access.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

   localparam int TO = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RegWriteM = 1'b0;
   logic [1:0]  ResultSrcM = 2'b00;
   logic        MemWriteM = 1'b0;
   logic [31:0] ALUResultM = '0;
   logic [31:0] WriteDataM = '0;
   logic [2:0]  funct3M = 3'b000;
   logic [31:0] ReadDataM;
   logic        StallM, MisalignedM, BusErrM;

   always #5 clk = ~clk;

   mem_stage_lsu_if #(.XLEN(32)) bus ();

   // responder-driven and manually driven slave signals
   logic        manual = 1'b0;
   logic        r_gnt = 1'b0, r_rvalid = 1'b0;
   logic [31:0] r_rdata = '0;
   logic        m_gnt = 1'b0, m_rvalid = 1'b0;
   logic [31:0] m_rdata = '0;

   assign bus.dmem_gnt    = manual ? m_gnt    : r_gnt;
   assign bus.dmem_rvalid = manual ? m_rvalid : r_rvalid;
   assign bus.dmem_rdata  = manual ? m_rdata  : r_rdata;

   mem_stage_lsu #(.TIMEOUT(TO), .XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .RegWriteM   (RegWriteM),
      .ResultSrcM  (ResultSrcM),
      .MemWriteM   (MemWriteM),
      .ALUResultM  (ALUResultM),
      .WriteDataM  (WriteDataM),
      .funct3M     (funct3M),
      .dmem        (bus.master),
      .ReadDataM   (ReadDataM),
      .StallM      (StallM),
      .MisalignedM (MisalignedM),
      .BusErrM     (BusErrM)
   );

   typedef struct { int g; int r; logic [31:0] rdata; } resp_t;
   typedef struct { logic [31:0] addr; logic [31:0] wdata; logic we; logic [3:0] be; } bus_t;
   typedef struct { logic mis; logic [31:0] rd; logic berr; int stall; } done_t;

   resp_t resp_q[$];
   bus_t  bus_q[$];
   done_t done_q[$];

   int          tests = 0;
   int          fails = 0;
   logic        mon_en = 1'b0;
   logic [31:0] model_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ----------------------------------------------------------- reference
   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ld_model(input logic [2:0] f3, input int o, input logic [31:0] d);
      int          sz = size_of(f3);
      logic [31:0] v  = d >> (8 * o);
      logic        u  = (f3 == 3'b100) || (f3 == 3'b101);
      if (sz == 1) begin
         v = v & 32'hFF;
         if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
         v = v & 32'hFFFF;
         if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   // Issue one instruction into MEM and hold it there while StallM is high.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int g, input int r, input logic [31:0] rdata);
      int    sz = size_of(f3);
      int    o  = int'(addr[1:0]);
      bus_t  b;
      done_t e;
      resp_t d;
      int    cyc = 0;
      logic  st_now;
      if (ld || st) begin
         if ((o % sz) != 0) begin
            e = '{mis: 1'b1, rd: model_rd, berr: 1'b0, stall: 0};
            done_q.push_back(e);
         end else begin
            b.addr = addr & 32'hFFFF_FFFC;
            b.we   = st;
            for (int k = 0; k < 4; k++) begin
               b.be[k]          = (k >= o) && (k < o + sz);
               b.wdata[8*k +: 8] = data[8*(k % sz) +: 8];
            end
            bus_q.push_back(b);
            e.mis = 1'b0;
            if (g > TO - 1) begin
               e.stall = 1 + TO;
               e.berr  = 1'b1;
               if (!st) model_rd = '0;
            end else if (st) begin
               e.stall = 2 + g;
               e.berr  = 1'b0;
            end else if (r == 0) begin
               e.stall = 2 + g + TO;
               e.berr  = 1'b1;
               model_rd = '0;
            end else begin
               e.stall = 2 + g + r;
               e.berr  = 1'b0;
               model_rd = ld_model(f3, o, rdata);
            end
            e.rd = model_rd;
            done_q.push_back(e);
            d = '{g: g, r: r, rdata: rdata};
            resp_q.push_back(d);
         end
      end
      @(negedge clk);
      RegWriteM  = ld;
      ResultSrcM = ld ? 2'b01 : 2'b00;
      MemWriteM  = st;
      funct3M    = f3;
      ALUResultM = addr;
      WriteDataM = data;
      #1;
      forever begin
         st_now = StallM;
         @(posedge clk);
         if (!st_now) break;
         cyc++;
         if (cyc > 200) begin
            check("stall_bound", 32'(cyc), 32'd0);
            break;
         end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      RegWriteM  = 1'b0;
      ResultSrcM = 2'b00;
      MemWriteM  = 1'b0;
   endtask

   // ------------------------------------------------------------ responder
   initial begin
      resp_t d;
      forever begin
         @(negedge clk);
         if (bus.dmem_req && !manual && resp_q.size() > 0) begin
            d = resp_q.pop_front();
            repeat (d.g) @(negedge clk);
            if (bus.dmem_req) begin
               r_gnt = 1'b1;
               @(negedge clk);
               r_gnt = 1'b0;
               if (!bus.dmem_we && d.r > 0) begin
                  repeat (d.r - 1) @(negedge clk);
                  r_rvalid = 1'b1;
                  r_rdata  = d.rdata;
                  @(negedge clk);
                  r_rvalid = 1'b0;
                  r_rdata  = $urandom;
               end
            end
         end
      end
   end

   // -------------------------------------------------------------- monitor
   initial begin
      logic  prev_stall = 1'b0;
      int    run = 0;
      done_t e;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            if (bus.dmem_req) begin
               if (bus_q.size() == 0) begin
                  check("unexpected_req", 32'd1, 32'd0);
               end else begin
                  check("req_addr",  bus.dmem_addr,  bus_q[0].addr);
                  check("req_wdata", bus.dmem_wdata, bus_q[0].wdata);
                  check("req_be",    32'(bus.dmem_be), 32'(bus_q[0].be));
                  check("req_we",    32'(bus.dmem_we), 32'(bus_q[0].we));
               end
            end
            if (StallM) run++;
            if (MisalignedM || (prev_stall && !StallM)) begin
               if (done_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = done_q.pop_front();
                  $display("[TB] done mis=%0b rd=%h berr=%0b stall=%0d", MisalignedM, ReadDataM, BusErrM, run);
                  check("misaligned", 32'(MisalignedM), 32'(e.mis));
                  check("read_data",  ReadDataM, e.rd);
                  check("bus_err",    32'(BusErrM), 32'(e.berr));
                  check("stall_cycles", 32'(run), 32'(e.stall));
                  if (!e.mis && bus_q.size() > 0) void'(bus_q.pop_front());
               end
               run = 0;
            end else if (BusErrM) begin
               check("stray_bus_err", 32'(BusErrM), 32'd0);
            end
            prev_stall = StallM;
         end
      end
   end

   // ------------------------------------------------------------- watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ----------------------------------------------------------------- main
   initial begin
      int          op, g, r, waitc;
      logic        ld, st;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req",   32'(bus.dmem_req), 32'd0);
      check("rst_stall", 32'(StallM), 32'd0);
      check("rst_rdata", ReadDataM, 32'd0);
      check("rst_addr",  bus.dmem_addr, 32'd0);
      check("rst_berr",  32'(BusErrM), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // directed cases
      issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);
      issue(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 2, 32'h8001_1234);
      issue(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 2, 32'h8001_1234);
      issue(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 5, 1, 32'hDEAD_BEEF);
      issue(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 1, 32'h0);
      issue(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 0, 0, 32'h1111_2222);
      issue(1'b0, 1'b1, 3'b010, 32'h0000_3008, 32'h1234_5678, TO, 0, 32'h0);
      issue(1'b1, 1'b1, 3'b001, 32'h0000_300A, 32'hCAFE_F00D, 1, 0, 32'h0);

      // randomized accesses
      for (int i = 0; i < 150; i++) begin
         op = $urandom_range(0, 9);
         ld = (op >= 1 && op <= 4) || op == 9;
         st = (op >= 5);
         g  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 4);
         r  = ($urandom_range(0, 9) == 0) ? 0  : $urandom_range(1, 5);
         issue(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, g, r, $urandom);
      end
      idle_inputs();

      waitc = 0;
      while (done_q.size() > 0 && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      check("drain_done", 32'(done_q.size()), 32'd0);

      // reset in the middle of a load
      mon_en = 1'b0;
      manual = 1'b1;
      @(negedge clk);
      RegWriteM  = 1'b1;
      ResultSrcM = 2'b01;
      MemWriteM  = 1'b0;
      funct3M    = 3'b010;
      ALUResultM = 32'h0000_0040;
      @(negedge clk);
      m_gnt = 1'b1;
      @(negedge clk);
      m_gnt = 1'b0;
      #1;
      check("pre_rst_stall", 32'(StallM), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_stall", 32'(StallM), 32'd0);
      check("arst_req",   32'(bus.dmem_req), 32'd0);
      check("arst_addr",  bus.dmem_addr, 32'd0);
      check("arst_be",    32'(bus.dmem_be), 32'd0);
      check("arst_rdata", ReadDataM, 32'd0);
      check("arst_berr",  32'(BusErrM), 32'd0);
      RegWriteM  = 1'b0;
      ResultSrcM = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      m_rvalid = 1'b1;
      m_rdata  = 32'h1234_5678;
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      check("late_rvalid_rdata", ReadDataM, 32'd0);
      check("late_rvalid_stall", 32'(StallM), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
